// File: rtl/data_memory_sized.sv
// ---------------------------------------------------------------------------
// data_memory_sized
//
// Synchronous RAM of DEPTH words of XLEN bits. Requests arrive on a
// valid/ready port. Accesses can be byte, half, word or double sized. Loads
// are sign- or zero-extended. Misaligned, out-of-range and illegal-size
// requests are reported as errors. After reset a hardware clear sequence
// zeroes every word before any request is accepted.
//
// Ports
//   clk           clock, all state updates on the rising edge
//   rst           synchronous reset, active high
//   req_valid     request present
//   req_ready     block accepts a request this cycle
//   req_write     1 = store, 0 = load
//   req_addr      byte address
//   req_size      0 = byte, 1 = half, 2 = word, 3 = double
//   req_unsigned  load: 1 = zero-extend, 0 = sign-extend
//   req_wdata     store data, right-justified
//   resp_valid    one-cycle pulse, response to last cycle's accepted request
//   resp_rdata    extended load data; 0 for stores and errors
//   resp_err      misaligned, out of range or illegal size
// ---------------------------------------------------------------------------
module data_memory_sized #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int NB = XLEN / 8;
  localparam int BO = $clog2(NB);

  // Any address bit at or above this mask makes the request out of range.
  localparam logic [XLEN-1:0] RANGE_MASK = {XLEN{1'b1}} << (BO + AW);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
  logic            req_ready_q, req_ready_d;
  logic            resp_valid_q, resp_valid_d;
  logic            resp_err_q, resp_err_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;

  logic [XLEN-1:0] mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;

  // Request decode
  logic            accept;
  logic [AW-1:0]   word_idx;
  logic [BO-1:0]   byte_off;
  logic [BO+2:0]   bit_shift;
  logic [3:0]      size_bytes;
  logic            misaligned;
  logic            out_of_range;
  logic            bad_size;
  logic            req_err;

  // Datapath
  logic [XLEN-1:0] cur_word;
  logic [XLEN-1:0] rd_shifted;
  logic [XLEN-1:0] low_mask;
  logic [XLEN-1:0] top_mask;
  logic [XLEN-1:0] load_val;
  logic [NB-1:0]   byte_en;
  logic [XLEN-1:0] wr_mask;
  logic [XLEN-1:0] wr_bits;
  logic [XLEN-1:0] merged;

  assign accept     = req_valid & req_ready_q;
  assign word_idx   = req_addr[BO +: AW];
  assign byte_off   = req_addr[BO-1:0];
  assign bit_shift  = {byte_off, 3'b000};
  assign size_bytes = 4'd1 << req_size;

  assign misaligned   = |(req_addr[2:0] & 3'(size_bytes - 4'd1));
  assign out_of_range = |(req_addr & RANGE_MASK);
  assign bad_size     = (XLEN == 32) && (req_size == 2'd3);
  assign req_err      = misaligned | out_of_range | bad_size;

  assign cur_word = mem[word_idx];

  // Load path: right-justify the selected bytes, then extend. low_mask covers
  // the access width; top_mask isolates its sign bit without variable indexing.
  always_comb begin
    rd_shifted = cur_word >> bit_shift;
    low_mask   = ~({XLEN{1'b1}} << {size_bytes, 3'b000});
    top_mask   = low_mask ^ (low_mask >> 1);
    load_val   = rd_shifted & low_mask;
    if (!req_unsigned && |(rd_shifted & top_mask)) begin
      load_val = load_val | ~low_mask;
    end
  end

  // Store path: merge the shifted store bytes into the current word so that
  // untouched bytes keep their contents.
  always_comb begin
    byte_en = NB'((9'h1 << size_bytes) - 9'h1) << byte_off;
    wr_bits = req_wdata << bit_shift;
    for (int b = 0; b < NB; b++) begin
      wr_mask[8*b +: 8] = {8{byte_en[b]}};
    end
    merged = (cur_word & ~wr_mask) | (wr_bits & wr_mask);
  end

  // Next-state and output logic.
  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    req_ready_d  = (state_q == S_READY);
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;
    mem_we       = 1'b0;
    mem_waddr    = word_idx;
    mem_wdata    = merged;

    unique case (state_q)
      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = '0;
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (accept) begin
          resp_valid_d = 1'b1;
          if (req_err) begin
            resp_err_d = 1'b1;
          end else if (req_write) begin
            mem_we = 1'b1;
          end else begin
            resp_rdata_d = load_val;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_cnt_q    <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // NOTE: the array has no reset term; it stays an inferable RAM and the
  // clear sequence zeroes it instead. Writes are blocked while rst is high.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// ---------------------------------------------------------------------------
// tb_data_memory_sized
//
// Bench for data_memory_sized. A 64-bit, 16-word instance is driven through
// a scoreboard: each accepted request pushes its expected response and a
// negedge monitor pops and compares it. A 32-bit instance covers the
// illegal-size case.
// ---------------------------------------------------------------------------
module tb_data_memory_sized;

  localparam int DEPTH = 16;

  logic        clk;
  logic        rst;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  logic        b_valid;
  logic        b_ready;
  logic        b_write;
  logic [31:0] b_addr;
  logic [1:0]  b_size;
  logic        b_unsigned;
  logic [31:0] b_wdata;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];

  typedef struct {
    logic        wr;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
  } vec_t;

  vec_t vecs[$];

  data_memory_sized #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  data_memory_sized #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (b_valid),
    .req_ready    (b_ready),
    .req_write    (b_write),
    .req_addr     (b_addr),
    .req_size     (b_size),
    .req_unsigned (b_unsigned),
    .req_wdata    (b_wdata),
    .resp_valid   (b_rvalid),
    .resp_rdata   (b_rdata),
    .resp_err     (b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor: an expectation pushed at an accept edge must be met at
  // the following negedge; a response with nothing expected is an error.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({e.name, "_valid"}, 64'(resp_valid), 64'd1);
      check({e.name, "_err"}, 64'(resp_err), 64'(e.err));
      check({e.name, "_rdata"}, resp_rdata, e.rdata);
    end else if (resp_valid) begin
      check("spurious_resp", 64'(resp_valid), 64'd0);
    end
  end

  // Issue one request on the 64-bit port; the expectation is queued on the
  // edge that accepts it.
  task automatic issue(input string name, input logic wr, input logic [63:0] addr,
                       input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                       input logic exp_err, input logic [63:0] exp_rdata);
    int guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!req_ready) check({name, "_ready_timeout"}, 64'(req_ready), 64'd1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    @(posedge clk);
    exp_q.push_back('{name: name, err: exp_err, rdata: exp_rdata});
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges from rst being released until req_ready rises.
  task automatic count_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!req_ready && n < 200);
  endtask

  task automatic reset_pulse(input string name);
    int n;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    count_ready(n);
    check({name, "_ready_latency"}, 64'(n), 64'(DEPTH + 1));
  endtask

  task automatic issue32(input string name, input logic wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic exp_err, input logic [31:0] exp_rdata);
    int guard = 0;
    while (!b_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    b_valid    = 1'b1;
    b_write    = wr;
    b_addr     = addr;
    b_size     = size;
    b_unsigned = uns;
    b_wdata    = wdata;
    @(posedge clk);
    #1;
    b_valid = 1'b0;
    check({name, "_valid"}, 64'(b_rvalid), 64'd1);
    check({name, "_err"}, 64'(b_err), 64'(exp_err));
    check({name, "_rdata"}, 64'(b_rdata), 64'(exp_rdata));
  endtask

  initial begin
    int n;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0;
    b_valid = 1'b0; b_write = 1'b0; b_addr = '0; b_size = '0;
    b_unsigned = 1'b0; b_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    rst = 1'b0;
    count_ready(n);
    check("init_ready_latency", 64'(n), 64'(DEPTH + 1));

    // Fill with garbage, reset, and expect every word cleared
    for (int i = 0; i < DEPTH; i++) begin
      issue($sformatf("fill%0d", i), 1'b1, 64'(i * 8), 2'd3, 1'b0,
            64'hA5A5_5A5A_0000_0000 | 64'(i + 1), 1'b0, 64'd0);
    end
    reset_pulse("clear");
    for (int i = 0; i < DEPTH; i++) begin
      issue($sformatf("zero%0d", i), 1'b0, 64'(i * 8), 2'd3, 1'b0, 64'd0, 1'b0, 64'd0);
    end

    // Store attempted while rst is held must not reach memory or respond
    issue("pre32", 1'b1, 64'd32, 2'd3, 1'b0, 64'd7, 1'b0, 64'd0);
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd32;
    req_size = 2'd3; req_wdata = 64'd5;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; req_valid = 1'b0;
    count_ready(n);
    check("store_in_rst_latency", 64'(n), 64'(DEPTH + 1));
    issue("load32", 1'b0, 64'd32, 2'd3, 1'b0, 64'd0, 1'b0, 64'd0);

    // Table-driven sized accesses, issued back to back
    vecs.push_back('{1'b1, 64'd8,   2'd3, 1'b0, 64'h1122_3344_5566_7788, 1'b0, 64'd0});
    vecs.push_back('{1'b1, 64'd10,  2'd0, 1'b0, 64'h0000_0000_0000_FFAB, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 64'd8,   2'd3, 1'b0, 64'd0, 1'b0, 64'h1122_3344_55AB_7788});
    vecs.push_back('{1'b0, 64'd10,  2'd0, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB});
    vecs.push_back('{1'b0, 64'd10,  2'd0, 1'b1, 64'd0, 1'b0, 64'h0000_0000_0000_00AB});
    vecs.push_back('{1'b0, 64'd14,  2'd1, 1'b0, 64'd0, 1'b0, 64'h0000_0000_0000_1122});
    vecs.push_back('{1'b0, 64'd12,  2'd2, 1'b0, 64'd0, 1'b0, 64'h0000_0000_1122_3344});
    vecs.push_back('{1'b0, 64'd8,   2'd2, 1'b1, 64'd0, 1'b0, 64'h0000_0000_55AB_7788});
    vecs.push_back('{1'b0, 64'd11,  2'd0, 1'b0, 64'd0, 1'b0, 64'h0000_0000_0000_0055});
    vecs.push_back('{1'b1, 64'd20,  2'd2, 1'b0, 64'h0000_0000_8000_0001, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 64'd20,  2'd2, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_8000_0001});
    vecs.push_back('{1'b0, 64'd20,  2'd2, 1'b1, 64'd0, 1'b0, 64'h0000_0000_8000_0001});
    vecs.push_back('{1'b0, 64'd16,  2'd3, 1'b1, 64'd0, 1'b0, 64'h8000_0001_0000_0000});
    vecs.push_back('{1'b0, 64'd9,   2'd1, 1'b0, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 64'd128, 2'd2, 1'b0, 64'h1234_5678, 1'b1, 64'd0});
    vecs.push_back('{1'b0, 64'd0,   2'd3, 1'b0, 64'd0, 1'b0, 64'd0});
    vecs.push_back('{1'b1, 64'd10,  2'd2, 1'b0, 64'hFFFF_FFFF, 1'b1, 64'd0});
    vecs.push_back('{1'b0, 64'd8,   2'd3, 1'b0, 64'd0, 1'b0, 64'h1122_3344_55AB_7788});
    vecs.push_back('{1'b0, 64'd12,  2'd3, 1'b0, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 64'd26,  2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 64'd24,  2'd3, 1'b0, 64'd0, 1'b0, 64'h0000_0000_BEEF_0000});
    vecs.push_back('{1'b0, 64'd26,  2'd1, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_BEEF});
    vecs.push_back('{1'b0, 64'h8000_0000_0000_0008, 2'd3, 1'b0, 64'd0, 1'b1, 64'd0});
    vecs.push_back('{1'b1, 64'd120, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b0, 64'd0});
    vecs.push_back('{1'b0, 64'd124, 2'd2, 1'b1, 64'd0, 1'b0, 64'h0000_0000_CAFE_F00D});
    vecs.push_back('{1'b0, 64'd127, 2'd0, 1'b1, 64'd0, 1'b0, 64'h0000_0000_0000_00CA});
    for (int i = 0; i < vecs.size(); i++) begin
      issue($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].size,
            vecs[i].uns, vecs[i].wdata, vecs[i].err, vecs[i].rdata);
    end

    // Read-after-write on consecutive cycles
    issue("raw_store", 1'b1, 64'd40, 2'd1, 1'b0, 64'h0000_0000_0000_DEAD, 1'b0, 64'd0);
    issue("raw_load_s", 1'b0, 64'd40, 2'd1, 1'b0, 64'd0, 1'b0, 64'hFFFF_FFFF_FFFF_DEAD);
    issue("raw_load_u", 1'b0, 64'd40, 2'd1, 1'b1, 64'd0, 1'b0, 64'h0000_0000_0000_DEAD);
    issue("raw_wstore", 1'b1, 64'd48, 2'd2, 1'b0, 64'h0000_0000_0000_DEAD, 1'b0, 64'd0);
    issue("raw_wload", 1'b0, 64'd48, 2'd2, 1'b0, 64'd0, 1'b0, 64'h0000_0000_0000_DEAD);
    @(posedge clk);
    #1;
    check("idle_resp_valid", 64'(resp_valid), 64'd0);

    // Reset on the edge that would accept a load: no response
    rst = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd8; req_size = 2'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_accept_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_accept_ready", 64'(req_ready), 64'd0);
    rst = 1'b0;
    count_ready(n);
    check("rst_accept_latency", 64'(n), 64'(DEPTH + 1));

    // Reset the cycle after an accepted load: pulse ends at once
    issue("pre_rst_load", 1'b0, 64'd0, 2'd3, 1'b0, 64'd0, 1'b0, 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_after_accept_valid", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    count_ready(n);
    check("rst_after_accept_latency", 64'(n), 64'(DEPTH + 1));

    // Reset in the middle of the clear sequence restarts it
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_clear_ready", 64'(req_ready), 64'd0);
    reset_pulse("mid_clear");

    // 32-bit instance
    issue32("w32_store", 1'b1, 32'd4, 2'd2, 1'b0, 32'h89AB_CDEF, 1'b0, 32'd0);
    issue32("w32_load", 1'b0, 32'd4, 2'd2, 1'b1, 32'd0, 1'b0, 32'h89AB_CDEF);
    issue32("w32_half", 1'b0, 32'd6, 2'd1, 1'b0, 32'd0, 1'b0, 32'hFFFF_89AB);
    issue32("w32_size3", 1'b0, 32'd0, 2'd3, 1'b0, 32'd0, 1'b1, 32'd0);
    issue32("w32_range", 1'b0, 32'd64, 2'd2, 1'b0, 32'd0, 1'b1, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
